// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the two-requester round-robin mux arbiter.
//   arb_state_e : grant FSM state. Encoding 2'd3 is unused and recovers to StIdle.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StG0   = 2'd1,
    StG1   = 2'd2
  } arb_state_e;

  // Mux select that goes with a given grant state; idle_sel is used when nobody owns the mux.
  function automatic logic sel_for_state(arb_state_e st, logic idle_sel);
    logic s;
    case (st)
      StG0:    s = 1'b0;
      StG1:    s = 1'b1;
      default: s = idle_sel;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Bus between two requesters and the round-robin mux arbiter.
//   req0/req1, din0/din1 : requester side (driven by master)
//   gnt0/gnt1, sel       : registered grant and mux select (driven by slave)
//   dout, dout_vld, busy : shared data stream, valid qualifier, arbiter-busy flag
interface mux2_rr_arbiter_if #(
  parameter int unsigned W = 8
);
  logic         req0;
  logic         req1;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [W-1:0] dout;
  logic         dout_vld;
  logic         busy;

  modport master (
    output req0, req1, din0, din1,
    input  gnt0, gnt1, sel, dout, dout_vld, busy
  );

  modport slave (
    input  req0, req1, din0, din1,
    output gnt0, gnt1, sel, dout, dout_vld, busy
  );
endinterface

// File: rtl/mux2_rr_arbiter_mux2_w.sv
// Combinational W-bit 2:1 mux.
//   a : selected when s=0
//   b : selected when s=1
//   s : select
//   y : output
module mux2_w #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one W-bit 2:1 mux between two requesters.
// Grant and select are registered (req in cycle n -> gnt in cycle n+1); dout is the mux of the
// registered select, so only the granted source ever reaches it.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of mux2_rr_arbiter_if (reqs/data in, grants/select/dout/status out)
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter bit          M        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  mux2_rr_arbiter_if.slave      bus
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             last_q, last_d;  // requester most recently released; 1 lets req0 win a tie
  logic             sel_q, sel_d;
  logic             hold_done;

  // Signed compare keeps this well-formed for MAX_HOLD=1, where every cycle is a release point.
  // Using >= rather than == also lets a late contender in once the count has saturated.
  assign hold_done = (int'(hold_q) + 1) >= int'(MAX_HOLD);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      last_q  <= 1'b1;
      sel_q   <= M;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        hold_d = '0;
        if (bus.req0 && (!bus.req1 || last_q)) begin
          state_d = StG0;
        end else if (bus.req1) begin
          state_d = StG1;
        end
      end
      StG0: begin
        if (!bus.req0) begin
          state_d = bus.req1 ? StG1 : StIdle;
        end else if (bus.req1 && hold_done) begin
          state_d = StG1;
        end
        if (state_d != StG0) begin
          hold_d = '0;
          last_d = 1'b0;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StG1: begin
        if (!bus.req1) begin
          state_d = bus.req0 ? StG0 : StIdle;
        end else if (bus.req0 && hold_done) begin
          state_d = StG0;
        end
        if (state_d != StG1) begin
          hold_d = '0;
          last_d = 1'b1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
      end
    endcase
    // Select moves on the same edge as the grant.
    sel_d = sel_for_state(state_d, M);
  end

  // Outputs
  always_comb begin
    bus.gnt0     = (state_q == StG0);
    bus.gnt1     = (state_q == StG1);
    bus.sel      = sel_q;
    bus.busy     = (state_q != StIdle);
    bus.dout_vld = (bus.gnt0 & bus.req0) | (bus.gnt1 & bus.req1);
  end

  mux2_w #(
    .W (W)
  ) u_dout_mux (
    .a (bus.din0),
    .b (bus.din1),
    .s (sel_q),
    .y (bus.dout)
  );

endmodule
